// File: rtl/stack_pkg.sv
// Shared types and helpers for the stack game engine.
// Latency: n/a (types, constants and combinational functions only).
// Backpressure: n/a.
package stack_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SLIDE,
        PLACE,
        LOST,
        WON
    } state_t;

    localparam int DEF_COLS = 8;
    localparam int DEF_ROWS = 8;

    // Helper functions work on a fixed wide vector; callers zero-extend a row.
    localparam int FN_W = 64;

    function automatic logic [6:0] popcount(input logic [FN_W-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < FN_W; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

    // Returns 0 for an all-zero input; callers only use it on non-zero rows.
    function automatic logic [5:0] lowest_set(input logic [FN_W-1:0] v);
        logic [5:0] idx;
        idx = '0;
        for (int i = FN_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 6'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/stack_tick_gen.sv
// Bar step timer: counts 0..period-1 and strobes o_tc on the terminal count.
// Latency: o_tc is combinational from the counter; a load/clear takes effect next edge.
// Backpressure: none; counting pauses while i_en is low.
// Ports: clk, rst (async active-low), i_en count enable, i_clr restart from 0,
//        i_ld/i_period load a new step period, o_tc one-cycle terminal-count strobe.
module stack_tick_gen #(
    parameter int TICK_DIV = 12500000,
    parameter int CW       = $clog2(TICK_DIV) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_clr,
    input  logic          i_ld,
    input  logic [CW-1:0] i_period,
    output logic          o_tc
);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_period;

    // A clear in the same cycle wins over the terminal count.
    assign o_tc = i_en && !i_clr && (r_cnt == r_period - CW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_period <= CW'(TICK_DIV);
        end else begin
            if (i_ld) begin
                r_period <= i_period;
            end
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_en) begin
                r_cnt <= o_tc ? '0 : r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/stack_game_engine.sv
// Stack game engine: sliding bar, drop/overlap placement, frame and score outputs.
// Latency: drop in cycle N -> frozen row and score visible after edge N+2.
// Backpressure: none; drop/start pulses outside the states that use them are dropped.
// Ports: clk, rst (async active-low), start/drop pulses in; matrix_out frame
//        (row 0 at bits [COLS-1:0]), score, busy, game_over, win out.
// Build option: define STACK_SPEEDUP_EN to shorten the step period on higher rows.
module stack_game_engine
    import stack_pkg::*;
#(
    parameter int TICK_DIV   = 12500000,
    parameter int COLS       = DEF_COLS,
    parameter int ROWS       = DEF_ROWS,
    parameter int INIT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 drop,
    output logic [ROWS*COLS-1:0] matrix_out,
    output logic [31:0]          score,
    output logic                 busy,
    output logic                 game_over,
    output logic                 win
);

    localparam int R_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int P_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int W_W = $clog2(COLS + 1);
    localparam int CW  = $clog2(TICK_DIV) + 1;

    state_t                      r_state;
    logic [ROWS-1:0][COLS-1:0]   r_frame;
    logic [31:0]                 r_score;
    logic                        r_busy;
    logic                        r_game_over;
    logic                        r_win;
    logic [R_W-1:0]              r_row;
    logic [P_W-1:0]              r_pos;
    logic [W_W-1:0]              r_width;
    logic                        r_dir_left;

    logic [COLS-1:0]             w_bar;
    logic [COLS-1:0]             w_below;
    logic [COLS-1:0]             w_keep;
    logic [W_W-1:0]              w_keep_cnt;
    logic [P_W-1:0]              w_keep_lsb;
    logic [32:0]                 w_score_sum;
    logic                        w_last_row;
    logic                        w_restart;
    logic                        w_advance;
    logic                        w_tick_ld;
    logic                        w_tc;
    logic [CW-1:0]               w_period;
    logic [ROWS-1:0][COLS-1:0]   w_matrix;

    // Bar: width ones starting at column pos.
    always_comb begin
        w_bar = '0;
        for (int c = 0; c < COLS; c++) begin
            if (c >= int'(r_pos) && c < int'(r_pos) + int'(r_width)) begin
                w_bar[c] = 1'b1;
            end
        end
    end

    // The bottom row has nothing beneath it, so the whole bar survives there.
    assign w_below     = (r_row == '0) ? '1 : r_frame[r_row - R_W'(1)];
    assign w_keep      = w_bar & w_below;
    assign w_keep_cnt  = W_W'(popcount(FN_W'(w_keep)));
    assign w_keep_lsb  = P_W'(lowest_set(FN_W'(w_keep)));
    assign w_score_sum = {1'b0, r_score} + 33'(w_keep_cnt);
    assign w_last_row  = (r_row == R_W'(ROWS - 1));

    assign w_restart = ((r_state == IDLE) || (r_state == LOST) || (r_state == WON)) && start;
    assign w_advance = (r_state == PLACE) && (w_keep != '0) && !w_last_row;
    assign w_tick_ld = w_restart || w_advance;

`ifdef STACK_SPEEDUP_EN
    // Period for the row about to be entered, floored at a quarter of TICK_DIV.
    always_comb begin
        int v_row;
        int v_per;
        v_row = w_advance ? int'(r_row) + 1 : 0;
        v_per = TICK_DIV - v_row * (TICK_DIV / 16);
        if (v_per < TICK_DIV / 4) begin
            v_per = TICK_DIV / 4;
        end
        w_period = CW'(v_per);
    end
`else
    assign w_period = CW'(TICK_DIV);
`endif

    stack_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CW       (CW)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .i_en     (r_state == SLIDE),
        .i_clr    (w_tick_ld),
        .i_ld     (w_tick_ld),
        .i_period (w_period),
        .o_tc     (w_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_frame     <= '0;
            r_score     <= '0;
            r_busy      <= 1'b0;
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
            r_row       <= '0;
            r_pos       <= '0;
            r_width     <= W_W'(INIT_WIDTH);
            r_dir_left  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, LOST, WON: begin
                    if (start) begin
                        r_state     <= SLIDE;
                        r_frame     <= '0;
                        r_score     <= '0;
                        r_busy      <= 1'b1;
                        r_game_over <= 1'b0;
                        r_win       <= 1'b0;
                        r_row       <= '0;
                        r_pos       <= '0;
                        r_width     <= W_W'(INIT_WIDTH);
                        r_dir_left  <= 1'b0;
                    end
                end
                SLIDE: begin
                    // Drop freezes the bar as displayed; a coincident step is discarded.
                    if (drop) begin
                        r_state <= PLACE;
                    end else if (w_tc) begin
                        if (int'(r_width) == COLS) begin
                            r_pos <= '0;
                        end else if (!r_dir_left) begin
                            if (int'(r_pos) + int'(r_width) == COLS) begin
                                r_dir_left <= 1'b1;
                                r_pos      <= r_pos - P_W'(1);
                            end else begin
                                r_pos <= r_pos + P_W'(1);
                            end
                        end else if (r_pos == '0) begin
                            r_dir_left <= 1'b0;
                            r_pos      <= r_pos + P_W'(1);
                        end else begin
                            r_pos <= r_pos - P_W'(1);
                        end
                    end
                end
                PLACE: begin
                    r_frame[r_row] <= w_keep;
                    if (w_keep == '0) begin
                        r_state     <= LOST;
                        r_busy      <= 1'b0;
                        r_game_over <= 1'b1;
                    end else begin
                        r_width <= w_keep_cnt;
                        r_pos   <= w_keep_lsb;
                        r_score <= w_score_sum[32] ? '1 : w_score_sum[31:0];
                        if (w_last_row) begin
                            r_state     <= WON;
                            r_busy      <= 1'b0;
                            r_game_over <= 1'b1;
                            r_win       <= 1'b1;
                        end else begin
                            r_row   <= r_row + R_W'(1);
                            r_state <= SLIDE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Frozen rows plus the live bar on the current row while a game is running.
    always_comb begin
        w_matrix = r_frame;
        if (r_busy) begin
            w_matrix[r_row] = r_frame[r_row] | w_bar;
        end
    end

    assign matrix_out = w_matrix;
    assign score      = r_score;
    assign busy       = r_busy;
    assign game_over  = r_game_over;
    assign win        = r_win;

endmodule

// File: doc/stack_game_engine.md
Name: stack_game_engine

Overview:
- Game engine for the "stack" game, between the shaped/decoded game buttons and the display sinks.
- Drives the 8x8 LED matrix controller's frame input and the score stream into the score display mux.
- A bar slides left/right on the current row. A drop press freezes it onto the row below, and only the overlap is kept.
- The stack grows until a miss (loss) or the top row is filled (win).

Parameters:
- TICK_DIV, 12500000: clk cycles per bar step (must be >= 2).
- COLS, 8: matrix columns.
- ROWS, 8: matrix rows.
- INIT_WIDTH, 3: starting bar width in columns (1..COLS).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse from process control; begins a new game.
- drop  in  1  one-cycle shaped button pulse (game button vector bit 0).
- matrix_out  out  ROWS*COLS  frame; row r = bits [COLS*r+COLS-1 : COLS*r]; row 0 is bottom; bit 0 of each row is column 0.
- score  out  32  unsigned count of lit cells successfully placed.
- busy  out  1  high in SLIDE and PLACE.
- game_over  out  1  high in LOST or WON.
- win  out  1  high in WON only.

Behaviour:
- Reset (rst=0, async): state IDLE; matrix_out=0, score=0, busy=0, game_over=0, win=0; tick counter=0, row=0, pos=0, dir=right, width=INIT_WIDTH.
- States: IDLE, SLIDE, PLACE, LOST, WON.
- IDLE/LOST/WON + start: clear frame, score=0, row=0, pos=0, dir=right, width=INIT_WIDTH, tick counter=0; go to SLIDE next edge.
- In all other cases, IDLE/LOST/WON hold their outputs and ignore drop.
- SLIDE, bar: bar = width ones shifted left by pos, shown on the current row. Rows above the current row are 0. Rows below are the frozen stack.
- SLIDE, tick counter: counts 0..TICK_DIV-1. On terminal count it wraps to 0 and the bar moves one column.
- SLIDE, bounce right: if dir=right and pos+width==COLS, dir flips to left and pos decrements in the same step.
- SLIDE, bounce left: if dir=left and pos==0, dir flips to right and pos increments.
- SLIDE, full-width bar: if width==COLS, pos stays 0 and dir is irrelevant.
- SLIDE + drop: go to PLACE. The bar position is the one visible in the cycle drop is high; a tick step in that same cycle is suppressed.
- PLACE (exactly one cycle), overlap rule: keep = bar AND row[row-1], or keep = bar when row==0.
  - keep==0: current row is cleared; go to LOST.
  - Otherwise: row[row] = keep, width = popcount(keep), pos = index of the lowest set bit of keep, score += popcount(keep).
  - If row==ROWS-1, go to WON; else row+1, tick counter=0, go to SLIDE.
- Latency: drop high in cycle N -> frozen row and score visible after edge N+2.
- Priority: start beats drop. start in SLIDE/PLACE is ignored, and a game is aborted only by reset.
- Mid-game reset: asynchronous return to the reset values above.
- Score saturates at 32'hFFFFFFFF; unreachable for ROWS=8, required anyway.

Optional Feature:
- Macro: STACK_SPEEDUP_EN.
- Defined: the step period is TICK_DIV - row*(TICK_DIV/16), with a floor of TICK_DIV/4, recomputed on entering SLIDE. Each row up speeds the bar.
- Undefined: the period is always TICK_DIV.
- Placement and scoring are identical in both builds.

Decomposition:
- Package stack_pkg: state enum (IDLE, SLIDE, PLACE, LOST, WON), default COLS/ROWS constants, popcount and lowest-set-bit functions.
- Sub-module stack_tick_gen: loadable period, clear input, one-cycle terminal-count strobe.
- Engine FSM, bar position and frame registers stay in stack_game_engine.

Test Plan (TICK_DIV=4):
- Reset/idle: rst low then high -> matrix_out=0, score=0, busy=0, game_over=0, win=0; drop pulses cause no change.
- Bounce: start, no drop, 40 cycles -> row 0 bar walks 0x07,0x0E,...,0xE0, then 0x70, with a step every 4 cycles and reversal at both edges.
- First drop: start, drop while row 0 = 0x07 -> two edges later row0=0x07, score=3, row 1 sliding 0x07.
- Partial overlap: row0=0x07; drop with row1 bar=0x1C -> row1=0x04, width=1, score=4.
- Miss: row0=0x07; drop with row1 bar=0x38 -> row1=0x00, game_over=1, win=0, score=3; a later drop is ignored and start restarts with score=0.
- Win, plus reset mid-game: drop with full alignment every row -> after row 7, win=1, game_over=1, score=24; rst low while in SLIDE -> outputs clear immediately, without waiting for a clock edge.
